// File: rtl/intel_iopll_reset_seq_pkg.sv
// Shared types and helpers for the IOPLL reset sequencer.
package intel_iopll_reset_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_STABLE = 2'd1,
        S_DELAY  = 2'd2,
        S_RUN    = 2'd3
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Width needed to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/intel_iopll_bit_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-high reset to 0.
module intel_iopll_bit_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/intel_iopll_reset_sequencer.sv
// Turns the raw IOPLL locked indication into a qualified lock and a synchronously released reset.
// Optional saturating lock-loss counter enabled by IOPLL_LOCK_LOSS_COUNT_EN.
module intel_iopll_reset_sequencer
    import intel_iopll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  locked_in,
    output logic                  reset_out,
    output logic                  locked_out,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES, RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_TERM  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_TERM = CNT_W'(RELEASE_CYCLES - 1);

    logic             lock_s;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;

    intel_iopll_bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .reset(reset),
        .d    (locked_in),
        .q    (lock_s)
    );

    // Loss of lock is tested before the terminal count so it always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_HOLD;
            cnt        <= '0;
            reset_out  <= 1'b1;
            locked_out <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    cnt        <= '0;
                    reset_out  <= 1'b1;
                    locked_out <= 1'b0;
                    if (lock_s) begin
                        state <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt == STABLE_TERM) begin
                        state      <= S_DELAY;
                        cnt        <= '0;
                        locked_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DELAY: begin
                    if (!lock_s) begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        locked_out <= 1'b0;
                    end else if (cnt == RELEASE_TERM) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        reset_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state      <= S_HOLD;
                        reset_out  <= 1'b1;
                        locked_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_HOLD;
                    cnt        <= '0;
                    reset_out  <= 1'b1;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef IOPLL_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    // Only a drop out of S_RUN counts; aborted qualifications do not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_cnt <= '0;
        end else if (state == S_RUN && !lock_s && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_count = loss_cnt;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_intel_iopll_reset_sequencer.sv
// Directed self-checking bench for intel_iopll_reset_sequencer (8/4 and 1/1 qualification configs).
module tb_intel_iopll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked_in;
    logic       a_rst, a_lck, b_rst, b_lck;
    logic [7:0] a_cnt, b_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef IOPLL_LOCK_LOSS_COUNT_EN
    localparam int LC_EN = 1;
`else
    localparam int LC_EN = 0;
`endif

    always #5 clk = ~clk;

    intel_iopll_reset_sequencer #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (8),
        .RELEASE_CYCLES(4)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .locked_in      (locked_in),
        .reset_out      (a_rst),
        .locked_out     (a_lck),
        .lock_loss_count(a_cnt)
    );

    intel_iopll_reset_sequencer #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1),
        .RELEASE_CYCLES(1)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .locked_in      (locked_in),
        .reset_out      (b_rst),
        .locked_out     (b_lck),
        .lock_loss_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive locked_in ahead of the next rising edge, then sample just after it.
    task automatic run_edge(input logic lk);
        locked_in = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        locked_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        locked_in = 1'b0;

        // Power-up and reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_reset_out", a_rst, 1);
        check("rst_a_locked_out", a_lck, 0);
        check("rst_a_count", a_cnt, 0);
        check("rst_b_reset_out", b_rst, 1);
        @(negedge clk);
        reset = 1'b0;

        // Clean qualification: edge 0 is the first high sample
        for (int e = 0; e <= 15; e++) begin
            run_edge(1'b1);
            check("t1_a_locked", a_lck, (e >= 11) ? 1 : 0);
            check("t1_a_reset", a_rst, (e < 15) ? 1 : 0);
            check("t1_b_locked", b_lck, (e >= 4) ? 1 : 0);
            check("t1_b_reset", b_rst, (e < 5) ? 1 : 0);
        end

        // Two-cycle glitch sampled at edges 5 and 6
        apply_reset();
        for (int e = 0; e <= 22; e++) begin
            run_edge((e == 5 || e == 6) ? 1'b0 : 1'b1);
            check("t2_a_locked", a_lck, (e >= 18) ? 1 : 0);
            check("t2_a_reset", a_rst, (e < 22) ? 1 : 0);
            check("t2_b_locked", b_lck, ((e >= 4 && e <= 7) || e >= 11) ? 1 : 0);
            check("t2_b_reset", b_rst, ((e >= 5 && e <= 7) || e >= 12) ? 0 : 1);
        end
        check("t2_a_count", a_cnt, 0);
        check("t2_b_count", b_cnt, LC_EN);

        // Lock loss from S_RUN: edge 0 is the first low sample
        for (int e = 0; e <= 3; e++) begin
            run_edge(1'b0);
            check("t3_a_reset", a_rst, (e >= 3) ? 1 : 0);
            check("t3_a_locked", a_lck, (e >= 3) ? 0 : 1);
            check("t3_b_reset", b_rst, (e >= 3) ? 1 : 0);
            check("t3_a_count", a_cnt, (e >= 3) ? LC_EN : 0);
        end
        check("t3_b_count", b_cnt, 2 * LC_EN);

        // Asynchronous reset while in S_DELAY
        apply_reset();
        for (int e = 0; e <= 12; e++) run_edge(1'b1);
        check("t4_a_in_delay_locked", a_lck, 1);
        check("t4_a_in_delay_reset", a_rst, 1);
        reset = 1'b1;
        #1;
        check("t4_async_reset_out", a_rst, 1);
        check("t4_async_locked_out", a_lck, 0);
        check("t4_async_b_reset_out", b_rst, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e <= 15; e++) begin
            run_edge(1'b1);
            check("t4_a_reset", a_rst, (e < 15) ? 1 : 0);
            check("t4_a_locked", a_lck, (e >= 11) ? 1 : 0);
        end

        // 300 lock-loss events from S_RUN
        apply_reset();
        check("t5_count_cleared", a_cnt, 0);
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 18; i++) run_edge(1'b1);
            if (c == 0) check("t5_a_run", a_rst, 0);
            for (int i = 0; i < 4; i++) run_edge(1'b0);
            if (c == 253) check("t5_a_count_254", a_cnt, 254 * LC_EN);
        end
        check("t5_a_count_sat", a_cnt, 255 * LC_EN);
        check("t5_b_count_sat", b_cnt, 255 * LC_EN);
        check("t5_a_reset_end", a_rst, 1);
        check("t5_a_locked_end", a_lck, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
